// File: rtl/vip1_fb_addr_gen_if.sv
// Pixel-address stream between the frame-buffer address generator and its
// consumer. A beat moves when addr_valid and addr_ready are both high.
interface vip1_fb_addr_gen_if;
  logic [21:0] addr_data;
  logic        addr_valid;
  logic        addr_ready;
  logic        eol;
  logic        eof;

  modport master (
    output addr_data,
    output addr_valid,
    output eol,
    output eof,
    input  addr_ready
  );

  modport slave (
    input  addr_data,
    input  addr_valid,
    input  eol,
    input  eof,
    output addr_ready
  );
endinterface

// File: rtl/vip1_fb_addr_gen.sv
// Frame-buffer address generator.
// Walks a width x height frame and emits one 22-bit pixel address per beat:
//   addr = base + row*stride + col
// The row*stride product comes from an external 10x12 multiplier, sampled once
// per line in SETUP, which costs one addr_valid=0 bubble per line. Address
// arithmetic either wraps modulo 2^22 or saturates at 22'h3FFFFF (SAT_EN).
// A zero width or height still passes through SETUP and then goes straight to
// FIN, so done appears two cycles after start and no beat is emitted.
module vip1_fb_addr_gen #(
  parameter bit SAT_EN = 1'b0
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               start,
  input  logic [21:0]        cfg_base,
  input  logic [11:0]        cfg_width,
  input  logic [9:0]         cfg_height,
  input  logic [11:0]        cfg_stride,
  output logic [9:0]         mul_a,
  output logic [11:0]        mul_b,
  input  logic [21:0]        mul_p,
  vip1_fb_addr_gen_if.master addr,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EMIT  = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Frame geometry captured at start; the cfg_* inputs are not looked at again
  // until the next frame.
  logic [21:0] base_reg;
  logic [11:0] width_reg;
  logic [9:0]  height_reg;
  logic [11:0] stride_reg;

  logic [9:0]  row_reg;
  logic [11:0] col_reg;
  logic [21:0] line_off_reg;
  logic [21:0] addr_data_reg;
  logic        eol_reg;
  logic        eof_reg;

  logic        geom_zero;
  logic        xfer;
  logic        last_row;
  logic [11:0] col_inc;
  logic        col_inc_last;
  logic [21:0] setup_off;
  logic [21:0] next_addr;

  // 22-bit add that either wraps or clamps to all-ones on carry out.
  function automatic logic [21:0] add22(input logic [21:0] a, input logic [21:0] b);
    logic [22:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (SAT_EN && sum[22]) begin
      add22 = 22'h3FFFFF;
    end else begin
      add22 = sum[21:0];
    end
  endfunction

  assign geom_zero    = (width_reg == 12'd0) || (height_reg == 10'd0);
  assign xfer         = (state_reg == EMIT) && addr.addr_ready;
  assign last_row     = (row_reg == (height_reg - 10'd1));
  assign col_inc      = col_reg + 12'd1;
  assign col_inc_last = (col_inc == (width_reg - 12'd1));
  assign setup_off    = add22(base_reg, mul_p);
  assign next_addr    = add22(line_off_reg, {10'd0, col_inc});

  // Row and stride only change on entry to SETUP, so the multiplier operands
  // naturally hold their last values everywhere else.
  assign mul_a = row_reg;
  assign mul_b = stride_reg;

  assign addr.addr_valid = (state_reg == EMIT);
  assign addr.addr_data  = addr_data_reg;
  assign addr.eol        = eol_reg;
  assign addr.eof        = eof_reg;
  assign busy            = (state_reg != IDLE);
  assign done            = (state_reg == FIN);

  // State register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = geom_zero ? FIN : EMIT;
      end
      EMIT: begin
        if (xfer) begin
          if (eof_reg) begin
            state_next = FIN;
          end else if (eol_reg) begin
            state_next = SETUP;
          end
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Config latch, row/col counters and the registered beat (address, eol, eof).
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      base_reg      <= '0;
      width_reg     <= '0;
      height_reg    <= '0;
      stride_reg    <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      line_off_reg  <= '0;
      addr_data_reg <= '0;
      eol_reg       <= 1'b0;
      eof_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            base_reg   <= cfg_base;
            width_reg  <= cfg_width;
            height_reg <= cfg_height;
            stride_reg <= cfg_stride;
            row_reg    <= '0;
            col_reg    <= '0;
          end
        end
        SETUP: begin
          // col is always 0 here, so the first beat of the line is line_off.
          if (!geom_zero) begin
            line_off_reg  <= setup_off;
            addr_data_reg <= setup_off;
            eol_reg       <= (width_reg == 12'd1);
            eof_reg       <= (width_reg == 12'd1) && last_row;
          end
        end
        EMIT: begin
          if (xfer) begin
            if (!eol_reg) begin
              col_reg       <= col_inc;
              addr_data_reg <= next_addr;
              eol_reg       <= col_inc_last;
              eof_reg       <= col_inc_last && last_row;
            end else if (!eof_reg) begin
              row_reg <= row_reg + 10'd1;
              col_reg <= '0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
